// File: rtl/router_fifo.sv
// router_fifo: per-port output FIFO of the packet router.
// Each entry holds a header flag and a data byte. A packet counter, loaded
// from the header length field, controls whether data_out holds or clears
// while no read is taking place.
// Optional build macro ROUTER_FIFO_ERR_EN adds the sticky outputs ovf_err
// and udf_err. Without the macro, requests that cannot be honoured are
// dropped silently.
module router_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             router_clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
`ifdef ROUTER_FIFO_ERR_EN
  ,
  output logic             ovf_err,
  output logic             udf_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 6;
  localparam int unsigned EW = WIDTH + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [EW-1:0]    mem_q [DEPTH];

  logic             wr_fire;
  logic             rd_fire;
  logic [EW-1:0]    rd_entry;

  // Occupancy flags are derived from the current pointers.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
            (wr_ptr_q[AW] != rd_ptr_q[AW]);
  end

  // A flush discards the requests of the same cycle.
  always_comb begin
    wr_fire  = write_enb && !full && !soft_reset;
    rd_fire  = read_enb && !empty && !soft_reset;
    rd_entry = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next state for the pointers, the packet counter and the read data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    if (soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      dout_d   = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        dout_d   = rd_entry[WIDTH-1:0];
        if (rd_entry[WIDTH]) begin
          // Header length field plus one byte for the trailing parity.
          cnt_d = CW'(rd_entry[WIDTH-1 -: CW]) + CW'(1);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
      end else if (cnt_q == '0) begin
        dout_d = '0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge router_clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  // Storage array. A hard reset clears every entry; a flush leaves the entries as they are.
  always_ff @(posedge router_clock) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  assign data_out = dout_q;

`ifdef ROUTER_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags for requests made against a full or empty FIFO.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (soft_reset) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (write_enb && full) begin
        ovf_d = 1'b1;
      end
      if (read_enb && empty) begin
        udf_d = 1'b1;
      end
    end
  end

  // Error flag registers.
  always_ff @(posedge router_clock) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`endif

endmodule
